jedro_1_dmem_responder: RTL and testbench
=========================================

// Module: jedro_1_dmem_responder
// PURPOSE
//  Responder (slave) end of the core's data-memory read/write port: a synthesizable
//  word-addressed RAM serving the LSU. It sits outside the core, across the data
//  memory interface. Fixed-latency pipelined reads, byte-enable writes,
//  out-of-range error responses and optional periodic backpressure for stress testing.
// PARAMETERS
//  DATA_WIDTH    32   data/address width in bits (only 32 supported)
//  MEM_WORDS     1024 memory depth in 32-bit words (power of 2)
//  READ_LATENCY  1    cycles from accepted read to rvalid_o (1..4)
//  STALL_PERIOD  0    0 = ready_o always 1; N>=2 = ready_o low 1 cycle of every N
//  INIT_FILE     ""   hex file loaded with $readmemh at elaboration if non-empty
// PORTS
//  clk_i     in   1   clock, rising edge
//  rstn_i    in   1   reset, asynchronous, active-low
//  en_i      in   1   request valid
//  ready_o   out  1   responder can accept; request accepted when en_i & ready_o
//  addr_i    in   32  byte address; bits [1:0] ignored
//  we_i      in   4   byte write enables; 0 = read, nonzero = write
//  wdata_i   in   32  write data, lane b = bits [8b+7:8b]
//  rdata_o   out  32  read data, valid while rvalid_o
//  rvalid_o  out  1   one-cycle pulse per accepted read
//  err_o     out  1   one-cycle pulse: accepted access was out of range
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk_i, rstn_i).
//  Reset: rdata_o=0, rvalid_o=0, err_o=0, ready_o=1, stall counter=0, response
//   pipeline flushed. Memory contents are not reset.
//  Reset mid-operation: in-flight reads are dropped, no rvalid_o after rstn_i deasserts.
//  Index = addr_i[31:2]. In range when index < MEM_WORDS.
//  Write (accepted, we_i!=0, in range): lanes with we_i[b]=1 updated at the accepting
//   edge; other lanes unchanged. No rvalid_o for writes.
//  Read (accepted, we_i==0, in range): word sampled at the accepting edge. rdata_o
//   and rvalid_o present exactly READ_LATENCY cycles later (READ_LATENCY=1 -> next cycle).
//  Out of range: no write, no array access. err_o pulses READ_LATENCY cycles
//   after accept. Reads also pulse rvalid_o with rdata_o=0 at that cycle.
//  Pipeline: shift register of depth READ_LATENCY carrying {valid, err, data}.
//   One accept per cycle. Responses return strictly in order, no bubbles inserted.
//  Ordering: a read accepted the cycle after a write to the same word returns the
//   new data. Write and read cannot coincide (single port).
//  rdata_o holds its last value when rvalid_o=0. Only rvalid_o qualifies it.
//  Backpressure: STALL_PERIOD=0 -> ready_o tied 1. Otherwise a free-running counter
//   counts 0..STALL_PERIOD-1 and wraps. ready_o=0 exactly when counter==STALL_PERIOD-1.
//   The counter advances regardless of en_i. A request with ready_o=0 is ignored:
//   no write, no response. The requester holds it until accepted.
//  Inputs are ignored when en_i=0. X on addr_i/we_i with en_i=0 is legal.
//  Elaboration error if READ_LATENCY outside 1..4 or STALL_PERIOD==1.
// TESTING
//  1. Write 0xDEADBEEF to 0x10, we_i=4'hF; then read 0x10 -> rvalid_o after
//     READ_LATENCY cycles, rdata_o=0xDEADBEEF, err_o=0.
//  2. Preload 0x11223344 at 0x20; write we_i=4'b0010, wdata_i=0xAABBCCDD; read ->
//     0x1122CC44.
//  3. READ_LATENCY=3: reads to 0x0,0x4,0x8,0xC in consecutive cycles -> four
//     consecutive rvalid_o pulses starting 3 cycles after the first, in order.
//  4. MEM_WORDS=1024: read at 0x1000 -> rvalid_o=1, err_o=1, rdata_o=0. Write at
//     0x1000 -> err_o=1, no rvalid_o, memory unchanged.
//  5. STALL_PERIOD=4: en_i held high -> ready_o pattern 1,1,1,0 repeating. Exactly
//     3 accepts per 4 cycles, writes only during ready_o=1.
//  6. Issue a read with READ_LATENCY=4; assert rstn_i=0 two cycles later -> outputs
//     0 immediately (async), and no rvalid_o after release.

Source files
------------

// File: rtl/jedro_1_dmem_responder_if.sv
// jedro_1_dmem_responder_if: data-memory request/response bundle between LSU (master) and RAM (slave)
// en_i/addr_i/we_i/wdata_i: request from master; ready_o: slave can accept
// rdata_o/rvalid_o/err_o: in-order response from slave
interface jedro_1_dmem_responder_if #(parameter int DATA_WIDTH = 32);
  logic en_i, ready_o, rvalid_o, err_o;
  logic [DATA_WIDTH-1:0] addr_i, wdata_i, rdata_o;
  logic [DATA_WIDTH/8-1:0] we_i;
  modport master(output en_i, addr_i, we_i, wdata_i, input ready_o, rdata_o, rvalid_o, err_o);
  modport slave(input en_i, addr_i, we_i, wdata_i, output ready_o, rdata_o, rvalid_o, err_o);
endinterface

// File: rtl/jedro_1_dmem_responder.sv
// jedro_1_dmem_responder: word-addressed RAM answering the core's data-memory port
// clk_i: rising-edge clock; rstn_i: asynchronous active-low reset
// bus (slave): request en_i/addr_i/we_i/wdata_i accepted when en_i & ready_o;
//   reads answered READ_LATENCY cycles later on rdata_o/rvalid_o, out-of-range
//   accesses flagged on err_o at the same latency
module jedro_1_dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS = 1024,
  parameter int READ_LATENCY = 1,
  parameter int STALL_PERIOD = 0,
  parameter string INIT_FILE = ""
) (
  input logic clk_i,
  input logic rstn_i,
  jedro_1_dmem_responder_if.slave bus
);
  localparam int IW = $clog2(MEM_WORDS);
  if (DATA_WIDTH != 32 || READ_LATENCY < 1 || READ_LATENCY > 4 || STALL_PERIOD == 1) begin : g_bad
    $error("jedro_1_dmem_responder: unsupported parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic acc, in_range, rd_acc, wr_acc, err_acc, unused;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [READ_LATENCY-1:0] pv, pe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pd;
  assign unused = ^bus.addr_i[1:0];
  assign acc = bus.en_i & bus.ready_o;
  assign idx = bus.addr_i[IW+1:2];
  assign in_range = {2'b0, bus.addr_i[31:2]} < 32'(MEM_WORDS);
  assign rd_acc = acc && bus.we_i == '0;
  assign wr_acc = acc && bus.we_i != '0 && in_range;
  assign err_acc = acc && !in_range;
  // out-of-range reads never touch the array and return zero
  assign rd_word = in_range ? mem[idx] : '0;
  always_ff @(posedge clk_i)
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (wr_acc && bus.we_i[b]) mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
  // data in each stage only moves with a valid entry, so the last stage holds
  // the most recent read result between pulses
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= rd_acc;
      pe[0] <= err_acc;
      if (rd_acc) pd[0] <= rd_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  assign bus.rvalid_o = pv[READ_LATENCY-1];
  assign bus.err_o = pe[READ_LATENCY-1];
  assign bus.rdata_o = pd[READ_LATENCY-1];
  if (STALL_PERIOD == 0) begin : g_nostall
    assign bus.ready_o = 1'b1;
  end else begin : g_stall
    localparam int CW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;
    logic [CW-1:0] cnt;
    // free-running, independent of en_i; last count is the stall cycle
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) cnt <= '0;
      else cnt <= cnt == CW'(STALL_PERIOD-1) ? '0 : cnt + 1'b1;
    assign bus.ready_o = cnt != CW'(STALL_PERIOD-1);
  end
endmodule

// File: tb/tb_jedro_1_dmem_responder.sv
// tb_jedro_1_dmem_responder: directed checks of three responder configurations
module tb_jedro_1_dmem_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  jedro_1_dmem_responder_if ba();
  jedro_1_dmem_responder_if bb();
  jedro_1_dmem_responder_if bc();
  jedro_1_dmem_responder #(.READ_LATENCY(1)) u_a (.clk_i(clk), .rstn_i(rstn), .bus(ba));
  jedro_1_dmem_responder #(.READ_LATENCY(3)) u_b (.clk_i(clk), .rstn_i(rstn), .bus(bb));
  jedro_1_dmem_responder #(.READ_LATENCY(4), .STALL_PERIOD(4)) u_c (.clk_i(clk), .rstn_i(rstn), .bus(bc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    ba.en_i = 1'b1; ba.addr_i = addr; ba.we_i = we; ba.wdata_i = wd;
    step();
    ba.en_i = 1'b0; ba.we_i = '0;
  endtask

  task automatic c_req(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    int n = 0;
    while (!bc.ready_o && n < 8) begin step(); n++; end
    total++;
    if (!bc.ready_o) begin bad++; $display("FAIL c_ready_wait got=%b want=1", bc.ready_o); end
    bc.en_i = 1'b1; bc.addr_i = addr; bc.we_i = we; bc.wdata_i = wd;
    step();
    bc.en_i = 1'b0; bc.we_i = '0;
  endtask

  task automatic c_read(input logic [31:0] addr, input logic [31:0] exp);
    c_req(addr, 4'h0, 32'h0);
    step(); step();
    total++;
    if (bc.rvalid_o !== 1'b0) begin bad++; $display("FAIL c_early_rvalid addr=%h got=%b want=0", addr, bc.rvalid_o); end
    step();
    total++;
    if ({bc.rvalid_o, bc.err_o, bc.rdata_o} !== {2'b10, exp})
      begin bad++; $display("FAIL c_read addr=%h got=%b%b/%h want=10/%h", addr, bc.rvalid_o, bc.err_o, bc.rdata_o, exp); end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total += 3;
    if ({ba.rvalid_o, ba.err_o, ba.ready_o, ba.rdata_o} !== {3'b001, 32'h0}) begin bad++; $display("FAIL reset_a got=%b%b%b/%h want=001/0", ba.rvalid_o, ba.err_o, ba.ready_o, ba.rdata_o); end
    if ({bb.rvalid_o, bb.err_o, bb.ready_o, bb.rdata_o} !== {3'b001, 32'h0}) begin bad++; $display("FAIL reset_b got=%b%b%b/%h want=001/0", bb.rvalid_o, bb.err_o, bb.ready_o, bb.rdata_o); end
    if ({bc.rvalid_o, bc.err_o, bc.ready_o, bc.rdata_o} !== {3'b001, 32'h0}) begin bad++; $display("FAIL reset_c got=%b%b%b/%h want=001/0", bc.rvalid_o, bc.err_o, bc.ready_o, bc.rdata_o); end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    a_req(32'h10, 4'hF, 32'hDEADBEEF);
    total++;
    if ({ba.rvalid_o, ba.err_o} !== 2'b00) begin bad++; $display("FAIL wr_no_resp got=%b%b want=00", ba.rvalid_o, ba.err_o); end
    a_req(32'h10, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.err_o, ba.rdata_o} !== {2'b10, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_basic got=%b%b/%h want=10/deadbeef", ba.rvalid_o, ba.err_o, ba.rdata_o); end
    step();
    total++;
    if ({ba.rvalid_o, ba.rdata_o} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_hold got=%b/%h want=0/deadbeef", ba.rvalid_o, ba.rdata_o); end
  endtask

  task automatic test_byte_enable();
    a_req(32'h20, 4'hF, 32'h11223344);
    a_req(32'h20, 4'b0010, 32'hAABBCCDD);
    a_req(32'h20, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.rdata_o} !== {1'b1, 32'h1122CC44}) begin bad++; $display("FAIL be_lane1 got=%b/%h want=1/1122cc44", ba.rvalid_o, ba.rdata_o); end
    a_req(32'h26, 4'hF, 32'h0);
    a_req(32'h24, 4'b1001, 32'hAABBCCDD);
    a_req(32'h27, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.rdata_o} !== {1'b1, 32'hAA0000DD}) begin bad++; $display("FAIL be_lane03 got=%b/%h want=1/aa0000dd", ba.rvalid_o, ba.rdata_o); end
  endtask

  task automatic test_out_of_range();
    a_req(32'h0, 4'hF, 32'h01020304);
    a_req(32'hFFC, 4'hF, 32'hCAFEF00D);
    a_req(32'h1000, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.err_o, ba.rdata_o} !== {2'b11, 32'h0}) begin bad++; $display("FAIL oor_read got=%b%b/%h want=11/0", ba.rvalid_o, ba.err_o, ba.rdata_o); end
    a_req(32'h1000, 4'hF, 32'h55555555);
    total++;
    if ({ba.rvalid_o, ba.err_o} !== 2'b01) begin bad++; $display("FAIL oor_write got=%b%b want=01", ba.rvalid_o, ba.err_o); end
    step();
    total++;
    if (ba.err_o !== 1'b0) begin bad++; $display("FAIL oor_pulse got=%b want=0", ba.err_o); end
    a_req(32'h0, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.err_o, ba.rdata_o} !== {2'b10, 32'h01020304}) begin bad++; $display("FAIL oor_no_alias got=%b%b/%h want=10/01020304", ba.rvalid_o, ba.err_o, ba.rdata_o); end
    a_req(32'hFFC, 4'h0, 32'h0);
    total++;
    if ({ba.rvalid_o, ba.err_o, ba.rdata_o} !== {2'b10, 32'hCAFEF00D}) begin bad++; $display("FAIL last_word got=%b%b/%h want=10/cafef00d", ba.rvalid_o, ba.err_o, ba.rdata_o); end
  endtask

  task automatic test_pipeline();
    logic [31:0] vals [4];
    for (int k = 0; k < 4; k++) begin
      vals[k] = 32'hA0A00000 + 32'(k * 17);
      bb.en_i = 1'b1; bb.addr_i = 32'(4 * k); bb.we_i = 4'hF; bb.wdata_i = vals[k];
      step();
    end
    bb.we_i = '0;
    for (int k = 0; k < 6; k++) begin
      bb.en_i = k < 4;
      bb.addr_i = 32'(4 * k);
      step();
      total++;
      if (k < 2 ? bb.rvalid_o !== 1'b0 : {bb.rvalid_o, bb.err_o, bb.rdata_o} !== {2'b10, vals[k < 2 ? 0 : k - 2]})
        begin bad++; $display("FAIL pipe_cycle%0d got=%b%b/%h", k, bb.rvalid_o, bb.err_o, bb.rdata_o); end
    end
    bb.en_i = 1'b0;
    step();
    total++;
    if (bb.rvalid_o !== 1'b0) begin bad++; $display("FAIL pipe_tail got=%b want=0", bb.rvalid_o); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int acc = 0;
    logic r;
    while (bc.ready_o && n < 8) begin step(); n++; end
    total++;
    if (bc.ready_o !== 1'b0) begin bad++; $display("FAIL stall_seen got=%b want=0", bc.ready_o); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (bc.ready_o !== ((i % 4) != 3)) begin bad++; $display("FAIL stall_pattern%0d got=%b want=%b", i, bc.ready_o, (i % 4) != 3); end
    end
    c_req(32'h80, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      r = bc.ready_o;
      bc.en_i = 1'b1; bc.we_i = 4'hF;
      bc.addr_i = r ? 32'h40 + 32'(4 * acc) : 32'h80;
      bc.wdata_i = r ? 32'hC0DE0000 + 32'(acc) : 32'h00000BAD;
      step();
      if (r) acc++;
    end
    bc.en_i = 1'b0; bc.we_i = '0;
    total++;
    if (acc != 6) begin bad++; $display("FAIL accept_count got=%0d want=6", acc); end
    for (int k = 0; k < 6; k++) c_read(32'h40 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
    c_read(32'h80, 32'h0);
  endtask

  task automatic test_reset_midflight();
    c_read(32'h44, 32'hC0DE0001);
    c_req(32'h40, 4'h0, 32'h0);
    step(); step();
    #2 rstn = 1'b0;
    #1;
    total += 2;
    if ({bc.rvalid_o, bc.err_o, bc.ready_o, bc.rdata_o} !== {3'b001, 32'h0}) begin bad++; $display("FAIL async_reset_c got=%b%b%b/%h want=001/0", bc.rvalid_o, bc.err_o, bc.ready_o, bc.rdata_o); end
    if (ba.rdata_o !== 32'h0) begin bad++; $display("FAIL async_reset_a got=%h want=0", ba.rdata_o); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({bc.rvalid_o, bc.rdata_o} !== {1'b0, 32'h0}) begin bad++; $display("FAIL flushed%0d got=%b/%h want=0/0", i, bc.rvalid_o, bc.rdata_o); end
    end
  endtask

  initial begin
    ba.en_i = 1'b0; ba.addr_i = '0; ba.we_i = '0; ba.wdata_i = '0;
    bb.en_i = 1'b0; bb.addr_i = '0; bb.we_i = '0; bb.wdata_i = '0;
    bc.en_i = 1'b0; bc.addr_i = '0; bc.we_i = '0; bc.wdata_i = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_pipeline();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
